// File: rtl/project_pkg.sv
// ---------------------------------------------------------------------------
// project_pkg
// Shared definitions for the PPM-over-UART streaming path:
//   - tx_state_type   : FSM state encoding of sram_ppm_uart_tx (S_IDLE = 0)
//   - RGB_BASE_ADDR   : SRAM word address of the first decoded RGB word
//   - RGB_WORD_COUNT  : number of 16-bit RGB words in a 320x240 image
//   - PPM_HEADER      : the 15-byte binary PPM header "P6\n320 240\n255\n"
//   - ppm_header_byte : range-safe lookup into PPM_HEADER
// ---------------------------------------------------------------------------
package project_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT1   = 3'd3,
        S_WAIT2   = 3'd4,
        S_SEND_HI = 3'd5,
        S_SEND_LO = 3'd6,
        S_DONE    = 3'd7
    } tx_state_type;

    localparam logic [17:0] RGB_BASE_ADDR  = 18'd146944;
    localparam int          RGB_WORD_COUNT = 115200;

    localparam int PPM_HEADER_LEN = 15;

    localparam logic [7:0] PPM_HEADER [PPM_HEADER_LEN] = '{
        8'h50, 8'h36, 8'h0A,                             // "P6\n"
        8'h33, 8'h32, 8'h30, 8'h20, 8'h32, 8'h34, 8'h30, // "320 240"
        8'h0A,                                           // "\n"
        8'h32, 8'h35, 8'h35, 8'h0A                       // "255\n"
    };

    // Index one past the end returns 0 so the caller can probe the
    // terminal index without reading outside the array.
    function automatic logic [7:0] ppm_header_byte(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 4'(PPM_HEADER_LEN)) begin
            b = PPM_HEADER[idx];
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 UART transmitter for a single byte: start bit (0), 8 data bits LSB
// first, stop bit (1), each bit CLKS_PER_BIT cycles long.
//
// Ports
//   Clock       in   system clock
//   Reset       in   synchronous, active-high; line returns high next edge
//   Load        in   request to send Data; accepted only while Ready = 1
//   Data[7:0]   in   byte to send
//   Tx          out  serial line, idle high
//   Ready       out  high when idle and during the final cycle of the stop
//                    bit, so a Load then gives back-to-back frames
// ---------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] Data,
    output logic       Tx,
    output logic       Ready
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic          busy_q,  busy_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic [3:0]    bit_q,   bit_d;    // 0 = start, 1..8 = data, 9 = stop
    logic [9:0]    frame_q, frame_d;  // bit 0 is the bit currently on the line
    logic          last_cycle;

    assign last_cycle = busy_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);
    assign Ready      = !busy_q || last_cycle;
    assign Tx         = busy_q ? frame_q[0] : 1'b1;

    always_comb begin
        busy_d  = busy_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        if (Load && Ready) begin
            busy_d  = 1'b1;
            baud_d  = '0;
            bit_d   = 4'd0;
            frame_d = {1'b1, Data, 1'b0};
        end else if (busy_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    frame_d = {1'b1, frame_q[9:1]};
                end
            end else begin
                baud_d = baud_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            frame_q <= '1;
        end else begin
            busy_q  <= busy_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/sram_ppm_uart_tx.sv
// ---------------------------------------------------------------------------
// sram_ppm_uart_tx
// Streams the decoded RGB image out of SRAM as a binary PPM file over the
// UART: the 15-byte header, then for each word at BASE_ADDR+k the high byte
// followed by the low byte. The SRAM read has a two-cycle latency, which
// appears on the line as 3 idle-high cycles before every word's high byte.
//
// Ports
//   Clock               in   50 MHz system clock
//   Reset               in   synchronous, active-high
//   Start               in   single-cycle launch; ignored unless idle
//   Busy                out  high from the cycle after Start until Done
//   Done                out  one-cycle pulse after the last stop bit
//   SRAM_address[17:0]  out  BASE_ADDR + k, modulo 2^18
//   SRAM_we_n           out  constant 1 (read only)
//   SRAM_read_data[15:0] in  read data, valid 2 cycles after the address
//   UART_TX_O           out  serial line, idle high
// ---------------------------------------------------------------------------
module sram_ppm_uart_tx
    import project_pkg::*;
#(
    parameter logic [17:0] BASE_ADDR    = RGB_BASE_ADDR,
    parameter int          WORD_COUNT   = RGB_WORD_COUNT,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        UART_TX_O
);

    localparam logic [16:0] LAST_K   = 17'(WORD_COUNT - 1);
    localparam logic [3:0]  HDR_STOP = 4'(PPM_HEADER_LEN);

    tx_state_type state_q,   state_d;
    logic [16:0]  k_q,       k_d;
    logic [3:0]   hdr_idx_q, hdr_idx_d;  // next header byte to load
    logic [7:0]   lo_byte_q, lo_byte_d;

    logic         tx_load;
    logic [7:0]   tx_data;
    logic         tx_ready;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .Clock(Clock),
        .Reset(Reset),
        .Load (tx_load),
        .Data (tx_data),
        .Tx   (UART_TX_O),
        .Ready(tx_ready)
    );

    // The address is a pure function of k; k only changes on the way into
    // S_REQ, so it is stable for the whole read.
    assign SRAM_address = BASE_ADDR + 18'(k_q);
    assign SRAM_we_n    = 1'b1;
    assign Busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done         = (state_q == S_DONE);

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        hdr_idx_d = hdr_idx_q;
        lo_byte_d = lo_byte_q;
        tx_load   = 1'b0;
        tx_data   = 8'h00;

        case (state_q)
            S_IDLE: begin
                // Loading byte 0 here puts its start bit on the line in
                // the very first Busy cycle.
                if (Start) begin
                    tx_load   = 1'b1;
                    tx_data   = ppm_header_byte(4'd0);
                    hdr_idx_d = 4'd1;
                    k_d       = '0;
                    state_d   = S_HEADER;
                end
            end

            S_HEADER: begin
                if (tx_ready) begin
                    if (hdr_idx_q == HDR_STOP) begin
                        state_d = S_REQ;
                    end else begin
                        tx_load   = 1'b1;
                        tx_data   = ppm_header_byte(hdr_idx_q);
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end
                end
            end

            S_REQ:   state_d = S_WAIT1;
            S_WAIT1: state_d = S_WAIT2;

            S_WAIT2: begin
                // Read data is valid now; the high byte goes straight to the
                // transmitter so only 3 idle cycles separate frames, and the
                // low byte is kept for later.
                tx_load   = 1'b1;
                tx_data   = SRAM_read_data[15:8];
                lo_byte_d = SRAM_read_data[7:0];
                state_d   = S_SEND_HI;
            end

            S_SEND_HI: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_data = lo_byte_q;
                    state_d = S_SEND_LO;
                end
            end

            S_SEND_LO: begin
                if (tx_ready) begin
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 17'd1;
                        state_d = S_REQ;
                    end
                end
            end

            S_DONE: begin
                k_d       = '0;
                hdr_idx_d = 4'd0;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: next-state values are computed with blocking '=' above; the
    // registers below take them with non-blocking '<=' only.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            hdr_idx_q <= 4'd0;
            lo_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            hdr_idx_q <= hdr_idx_d;
            lo_byte_q <= lo_byte_d;
        end
    end

endmodule

// File: tb/tb_sram_ppm_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_sram_ppm_uart_tx
// Bench for sram_ppm_uart_tx with CLKS_PER_BIT = 4, WORD_COUNT = 2 and a base
// address at the top of the SRAM so the second word wraps to address 0.
// A UART receiver model decodes the line; the expected stream is the header
// text followed by each word split into high and low bytes.
// ---------------------------------------------------------------------------
module tb_sram_ppm_uart_tx;

    localparam int          C     = 4;
    localparam int          W     = 2;
    localparam logic [17:0] BASE  = 18'h3FFFF;
    localparam int          FRAME = 10 * C;
    localparam int          DUR   = (15 + 2 * W) * FRAME + 3 * W + 1;

    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [31:0] exp_bytes;  // expected data bytes, first byte in [31:24]
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [17:0] addr;
    logic        we_n;
    logic [15:0] rdata;
    logic        tx;

    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] mem [0:262143];

    int cyc         = 0;
    int done_cnt    = 0;
    int frame_err   = 0;
    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_q[$];
    logic [7:0] model_q[$];
    string      hdr_text = "P6\n320 240\n255\n";

    sram_ppm_uart_tx #(
        .BASE_ADDR   (BASE),
        .WORD_COUNT  (W),
        .CLKS_PER_BIT(C)
    ) dut (
        .Clock         (clk),
        .Reset         (reset),
        .Start         (start),
        .Busy          (busy),
        .Done          (done),
        .SRAM_address  (addr),
        .SRAM_we_n     (we_n),
        .SRAM_read_data(rdata),
        .UART_TX_O     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM with a two-cycle read latency.
    always @(posedge clk) begin
        rd1 <= mem[addr];
        rd2 <= rd1;
    end
    assign rdata = rd2;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // UART receiver: samples each bit near its middle.
    initial begin : uart_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && tx === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx;
                end
                repeat (C) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w1);
        mem[BASE]          = w0;
        mem[BASE + 18'd1]  = w1;
        mem[BASE - 18'd1]  = 16'($urandom);
        mem[BASE + 18'd2]  = 16'($urandom);
    endtask

    task automatic model_header();
        model_q.delete();
        for (int i = 0; i < hdr_text.len(); i++) model_q.push_back(hdr_text[i]);
    endtask

    task automatic model_words(input logic [15:0] w0, input logic [15:0] w1);
        model_header();
        model_q.push_back(8'(w0 / 256));
        model_q.push_back(8'(w0 % 256));
        model_q.push_back(8'(w1 / 256));
        model_q.push_back(8'(w1 % 256));
    endtask

    task automatic do_transfer(input string tag, input bit poke_start, input bit start_on_done,
                               output logic [39:0] line_bits);
        int rx_base;
        int done_base;
        int fe_base;
        int t_start;
        int budget;
        logic [15:0] got;
        rx_base   = rx_q.size();
        done_base = done_cnt;
        fe_base   = frame_err;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        t_start = cyc;
        check({tag, " busy after start"}, 64'(busy), 64'd1);
        for (int j = 0; j < 40; j++) begin
            line_bits[j] = tx;
            @(negedge clk);
        end
        check({tag, " we_n while busy"}, 64'(we_n), 64'd1);
        budget = 0;
        while (done !== 1'b1 && budget < 4 * DUR) begin
            start = poke_start && (budget == 60);
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        check({tag, " done within budget"}, 64'(done), 64'd1);
        check({tag, " start-to-done cycles"}, 64'(cyc - t_start + 1), 64'(DUR));
        check({tag, " busy low with done"}, 64'(busy), 64'd0);
        if (start_on_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " idle after done"}, 64'(busy), 64'd0);
        repeat (3 * FRAME) @(negedge clk);
        check({tag, " done pulses"}, 64'(done_cnt - done_base), 64'd1);
        check({tag, " byte count"}, 64'(rx_q.size() - rx_base), 64'(model_q.size()));
        check({tag, " framing errors"}, 64'(frame_err - fe_base), 64'd0);
        for (int i = 0; i < model_q.size(); i++) begin
            got = (rx_base + i < rx_q.size()) ? {8'h00, rx_q[rx_base + i]} : 16'hDEAD;
            check($sformatf("%s byte %0d", tag, i), 64'(got), 64'(model_q[i]));
        end
    endtask

    initial begin
        vec_t        tbl [4];
        logic [39:0] lb;
        logic [39:0] exp_line;
        logic [9:0]  frame;
        logic [15:0] rw0;
        logic [15:0] rw1;
        bit          line_high;
        int          n;
        int          done_base;
        int          budget;

        tbl[0] = '{w0: 16'hA55A, w1: 16'h0001, exp_bytes: 32'hA5_5A_00_01};
        tbl[1] = '{w0: 16'h0000, w1: 16'hFFFF, exp_bytes: 32'h00_00_FF_FF};
        tbl[2] = '{w0: 16'h00FF, w1: 16'hFF00, exp_bytes: 32'h00_FF_FF_00};
        tbl[3] = '{w0: 16'h8001, w1: 16'h7E00, exp_bytes: 32'h80_01_7E_00};

        // Reset values.
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset tx", 64'(tx), 64'd1);
        check("reset address", 64'(addr), 64'(BASE));
        check("reset we_n", 64'(we_n), 64'd1);

        // Start together with Reset: Reset wins.
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("start+reset busy", 64'(busy), 64'd0);
        line_high = 1'b1;
        for (int j = 0; j < 2 * C; j++) begin
            if (tx !== 1'b1) line_high = 1'b0;
            @(negedge clk);
        end
        check("start+reset line idle", 64'(line_high), 64'd1);

        // Table-driven transfers. Entry 0 also checks the first frame bit
        // by bit, entry 1 pokes Start mid-header, entry 2 pokes Start in
        // the Done cycle.
        frame = {1'b1, 8'h50, 1'b0};
        for (int j = 0; j < 40; j++) exp_line[j] = frame[j / C];
        for (int i = 0; i < 4; i++) begin
            set_words(tbl[i].w0, tbl[i].w1);
            model_header();
            for (int b = 3; b >= 0; b--) model_q.push_back(tbl[i].exp_bytes[b*8 +: 8]);
            do_transfer($sformatf("vec%0d", i), i == 1, i == 2, lb);
            if (i == 0) check("first frame line bits", 64'(lb), 64'(exp_line));
        end

        // Reset during the high byte of word 1.
        set_words(tbl[0].w0, tbl[0].w1);
        done_base = done_cnt;
        n         = rx_q.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        while (rx_q.size() < n + 17 && budget < 2 * DUR) begin
            @(negedge clk);
            budget++;
        end
        while (tx !== 1'b0 && budget < 2 * DUR) begin
            @(negedge clk);
            budget++;
        end
        check("reset test bytes before word 1", 64'(rx_q.size() - n), 64'd17);
        check("reset test word 1 start bit", 64'(tx), 64'd0);
        repeat (2 * C) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid-byte reset tx", 64'(tx), 64'd1);
        check("mid-byte reset busy", 64'(busy), 64'd0);
        check("mid-byte reset done", 64'(done), 64'd0);
        check("mid-byte reset address", 64'(addr), 64'(BASE));
        reset = 1'b0;
        repeat (12 * C) @(negedge clk);
        check("no done after reset", 64'(done_cnt - done_base), 64'd0);
        check("idle after reset", 64'(busy), 64'd0);
        model_words(tbl[0].w0, tbl[0].w1);
        do_transfer("after reset", 1'b0, 1'b0, lb);

        // Random words against the reference stream.
        for (int r = 0; r < 5; r++) begin
            rw0 = 16'($urandom);
            rw1 = 16'($urandom);
            set_words(rw0, rw1);
            model_words(rw0, rw1);
            do_transfer($sformatf("rand%0d", r), 1'b0, 1'b0, lb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
